fsm_sequencer: RTL
==================

// Module: fsm_sequencer
// PURPOSE
//  Initiator for the go/jmp control FSM. Accepts a command over a valid/ready
//  handshake and drives go/jmp to walk the target FSM along the requested path.
//  Every cycle it checks the target's state and y1 against an internal model of the FSM.
//  Reports y1-high cycle count, busy cycles and pass/fail status.
//  Sits between the test/CPU command source and the FSM.
// PARAMETERS
//  HOLD_W   4    width of cmd_hold (extra cycles jmp is held in S3)
//  CYC_W    8    width of rsp_cycles / timeout counter
//  TIMEOUT  64   max busy cycles before abort (must be < 2**CYC_W)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       sequencer idle and accepting a command
//  cmd_path     in   2       0 full 0-1-2-3; 1 jump 0-3; 2 jump 1-3; 3 illegal
//  cmd_hold     in   HOLD_W  extra cycles in S3 with jmp=1
//  go           out  1       registered, to FSM
//  jmp          out  1       registered, to FSM
//  tgt_state    in   4       FSM current state (S0..S9 = 0..9)
//  tgt_y1       in   1       FSM output y1
//  rsp_valid    out  1       one-cycle pulse: response fields valid
//  rsp_status   out  2       0 OK, 1 MISMATCH, 2 TIMEOUT, 3 BADCMD
//  rsp_pulses   out  HOLD_W+2  count of cycles with tgt_y1=1
//  rsp_cycles   out  CYC_W   cycles with the target out of S0
// BEHAVIOUR
//  Reset: cmd_ready=1, go=0, jmp=0, rsp_valid=0, rsp_* = 0, FSM state IDLE, exp_state=S0.
//  Target FSM model (exp_state): S0: go&jmp->S3, go&!jmp->S1, else S0.
//   S1: jmp->S3 else S2; S2->S3; S3..S8: jmp->S3 else next; S9: jmp->S3 else S0.
//   y1 expected 1 only in S3 and S9.
//  States: IDLE, RUN, DONE.
//  IDLE: cmd_ready=1; accept on cmd_valid&cmd_ready. Latch path, hold_cnt=cmd_hold.
//   Clear counters. cmd_path=3: no go, one cycle later rsp_valid with BADCMD, back to IDLE.
//  Launch edge: go<=1, jmp<=(path==1). exp_state advances using the values driven.
//  RUN drive rules (registered, based on next exp_state):
//   S1: jmp=(path==2); S2: jmp=0.
//   S3: jmp=1 while hold_cnt!=0, decrement per S3 cycle; then 0.
//   S4..S9: jmp=0. go held 1 until exp_state returns to S0, then go=0.
//  Check, every RUN cycle: tgt_state!=exp_state or tgt_y1!=expected -> MISMATCH.
//   Check starts the cycle after the launch edge.
//   On any abort: go=jmp=0 at the next edge.
//  Counting per RUN cycle: rsp_cycles+1 if exp_state!=S0; rsp_pulses+1 if tgt_y1.
//   Counters saturate and do not wrap.
//  Normal end: exp_state reaches S0 with no mismatch -> DONE.
//   DONE: rsp_valid=1 for one cycle, status OK, then IDLE.
//   Expected results: pulses=hold+2; cycles=hold+9/7/8 for path 0/1/2.
//  TIMEOUT: busy cycles==TIMEOUT -> TIMEOUT status, abort.
//   Not reachable for legal commands with default params.
//  Priority when both occur in one cycle: MISMATCH > TIMEOUT.
//  cmd_ready=0 outside IDLE; cmd_valid while busy is ignored and is not queued.
//  rsp_* hold their value until the next accepted command.
//  Async reset mid-RUN: all outputs return to reset values at once; the FSM is reset externally.
// STRUCTURE
//  Shared package fsm_pkg: S0..S9 4-bit localparams; y1 decode function;
//   next-state function (state, go, jmp); status codes; path codes.
//   The model uses the next-state function; the target FSM should use it too.
//  One sub-module, fsm_model: registered exp_state plus expected y1.
//   Inputs: go/jmp, clear.
// TESTING
//  Bench instantiates the real FSM on the same clk/rst_n.
//  path=0 hold=0 -> states 1,2,3,4..9,0; rsp OK, pulses=2, cycles=9.
//  path=1 hold=3 -> S3 for 4 cycles; OK, pulses=5, cycles=10.
//  path=2 hold=0 -> 1,3,4..9,0; OK, pulses=2, cycles=8.
//  path=3 -> go stays 0; rsp_valid 1 cycle later with BADCMD; cmd_ready back to 1.
//  tgt_state forced to S2 while expecting S3 -> MISMATCH next cycle; go=jmp=0 following edge.
//  rst_n low for 1 cycle mid-S5 -> go=jmp=0, cmd_ready=1 immediately.
//   A new path=0 command then gives OK.
//  cmd_valid held through a run -> exactly one command accepted per run.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared definitions for the go/jmp target FSM and its sequencer:
// state codes, next-state/y1 decode, status and path codes.
package fsm_pkg;

   localparam logic [3:0] S0 = 4'd0;
   localparam logic [3:0] S1 = 4'd1;
   localparam logic [3:0] S2 = 4'd2;
   localparam logic [3:0] S3 = 4'd3;
   localparam logic [3:0] S4 = 4'd4;
   localparam logic [3:0] S5 = 4'd5;
   localparam logic [3:0] S6 = 4'd6;
   localparam logic [3:0] S7 = 4'd7;
   localparam logic [3:0] S8 = 4'd8;
   localparam logic [3:0] S9 = 4'd9;

   localparam logic [1:0] PATH_FULL = 2'd0;
   localparam logic [1:0] PATH_J03  = 2'd1;
   localparam logic [1:0] PATH_J13  = 2'd2;
   localparam logic [1:0] PATH_BAD  = 2'd3;

   localparam logic [1:0] ST_OK       = 2'd0;
   localparam logic [1:0] ST_MISMATCH = 2'd1;
   localparam logic [1:0] ST_TIMEOUT  = 2'd2;
   localparam logic [1:0] ST_BADCMD   = 2'd3;

   typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

   function automatic logic y1_of(input logic [3:0] s);
      return (s == S3) || (s == S9);
   endfunction

   function automatic logic [3:0] next_state(input logic [3:0] s, input logic go,
                                             input logic jmp);
      logic [3:0] n;
      n = S0;
      case (s)
         S0:      n = !go ? S0 : (jmp ? S3 : S1);
         S1:      n = jmp ? S3 : S2;
         S2:      n = S3;
         S9:      n = jmp ? S3 : S0;
         default: n = (s >= S3 && s <= S8) ? (jmp ? S3 : s + 4'd1) : S0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/fsm_model.sv
// Shadow copy of the target FSM: tracks the state the target should be in
// given the go/jmp values actually driven.
module fsm_model
   import fsm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       go,
   input  logic       jmp,
   output logic [3:0] exp_state,
   output logic [3:0] exp_next,
   output logic       exp_y1
);

   assign exp_next = next_state(exp_state, go, jmp);
   assign exp_y1   = y1_of(exp_state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     exp_state <= S0;
      else if (clear) exp_state <= S0;
      else            exp_state <= exp_next;
   end

endmodule

// File: rtl/fsm_sequencer.sv
// Command-driven initiator for the go/jmp FSM: walks the requested path,
// checks the target against a shadow model each cycle and reports the result.
module fsm_sequencer
   import fsm_pkg::*;
#(
   parameter int HOLD_W  = 4,
   parameter int CYC_W   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_path,
   input  logic [HOLD_W-1:0] cmd_hold,
   output logic              go,
   output logic              jmp,
   input  logic [3:0]        tgt_state,
   input  logic              tgt_y1,
   output logic              rsp_valid,
   output logic [1:0]        rsp_status,
   output logic [HOLD_W+1:0] rsp_pulses,
   output logic [CYC_W-1:0]  rsp_cycles
);

   localparam logic [CYC_W-1:0] TO_LAST = CYC_W'(TIMEOUT - 1);

   seq_state_t        state;
   logic [1:0]        path;
   logic [HOLD_W-1:0] hold_cnt;
   logic [CYC_W-1:0]  busy_cnt;
   logic [3:0]        exp_state, exp_next;
   logic              exp_y1, model_clear, mism, tmo;

   // Model is pinned to S0 outside RUN so each run starts from a known state.
   assign model_clear = (state != RUN);

   fsm_model u_model (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (model_clear),
      .go        (go),
      .jmp       (jmp),
      .exp_state (exp_state),
      .exp_next  (exp_next),
      .exp_y1    (exp_y1)
   );

   assign mism = (tgt_state != exp_state) || (tgt_y1 != exp_y1);
   assign tmo  = (busy_cnt == TO_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         go         <= 1'b0;
         jmp        <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_status <= ST_OK;
         rsp_pulses <= '0;
         rsp_cycles <= '0;
         path       <= PATH_FULL;
         hold_cnt   <= '0;
         busy_cnt   <= '0;
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready  <= 1'b0;
                  path       <= cmd_path;
                  hold_cnt   <= cmd_hold;
                  busy_cnt   <= '0;
                  rsp_status <= ST_OK;
                  rsp_pulses <= '0;
                  rsp_cycles <= '0;
                  if (cmd_path == PATH_BAD) begin
                     state      <= DONE;
                     rsp_valid  <= 1'b1;
                     rsp_status <= ST_BADCMD;
                  end else begin
                     state <= RUN;
                     go    <= 1'b1;
                     jmp   <= (cmd_path == PATH_J03);
                  end
               end
            end
            RUN: begin
               busy_cnt <= busy_cnt + 1'b1;
               if (exp_state != S0 && rsp_cycles != '1) rsp_cycles <= rsp_cycles + 1'b1;
               if (tgt_y1 && rsp_pulses != '1)          rsp_pulses <= rsp_pulses + 1'b1;
               if (mism || tmo) begin
                  state      <= DONE;
                  rsp_valid  <= 1'b1;
                  rsp_status <= mism ? ST_MISMATCH : ST_TIMEOUT;
                  go         <= 1'b0;
                  jmp        <= 1'b0;
               end else if (exp_next == S0) begin
                  state     <= DONE;
                  rsp_valid <= 1'b1;
                  go        <= 1'b0;
                  jmp       <= 1'b0;
               end else begin
                  // go/jmp are chosen for the state the target is about to enter
                  go <= 1'b1;
                  case (exp_next)
                     S1: jmp <= (path == PATH_J13);
                     S3: begin
                        jmp <= (hold_cnt != '0);
                        if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                     end
                     default: jmp <= 1'b0;
                  endcase
               end
            end
            DONE: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
